// File: rtl/sched_pkg.sv
// Shared scheduler constants, dispatch FSM state encoding and the slice-budget helper.
package sched_pkg;

   localparam int TID_W         = 4;
   localparam int INFO_W        = 32;
   localparam int SLICE_W       = 16;
   localparam int DEFAULT_SLICE = 100;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      OFFER  = 3'd2,
      RUN    = 3'd3,
      RETIRE = 3'd4
   } state_t;

   // A zero budget field means "use the default slice".
   function automatic logic [SLICE_W-1:0] slice_budget(input logic [SLICE_W-1:0] field);
      return (field == '0) ? SLICE_W'(DEFAULT_SLICE) : field;
   endfunction

endpackage

// File: rtl/slice_timer.sv
// Loadable saturating down-counter for the time slice, with a one-cycle expiry pulse
// on the edge where the count steps from 1 to 0.
module slice_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_next,
   output logic         expired
);

   logic [W-1:0] cnt_reg;
   logic         expired_reg;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (load) begin
         cnt_next = load_val;
      end else if (en && cnt_reg != '0) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg     <= '0;
         expired_reg <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         expired_reg <= en && !load && !clr && (cnt_reg == W'(1));
      end
   end

   assign cnt     = cnt_reg;
   assign expired = expired_reg;

endmodule

// File: rtl/sr_task_queue_head_dispatch.sv
// Queue read end: pops the head task, offers it to the processor, times its slice and
// hands unfinished tasks back to the tail with the residual slice folded into the info word.
module sr_task_queue_head_dispatch
   import sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [TID_W-1:0]   head_tid,
   input  logic [INFO_W-1:0]  head_info,
   input  logic               head_empty,
   input  logic               head_schden,
   output logic               dequeue,
   output logic               dispatch_valid,
   input  logic               dispatch_ready,
   output logic [TID_W-1:0]   dispatch_tid,
   output logic [INFO_W-1:0]  dispatch_info,
   input  logic               preempt,
   input  logic               yield,
   input  logic               task_done,
   output logic [TID_W-1:0]   running_tid,
   output logic [SLICE_W-1:0] slice_cnt,
   output logic               slice_expired,
   output logic               reenq_valid,
   output logic [TID_W-1:0]   reenq_tid,
   output logic [INFO_W-1:0]  reenq_info,
   output logic               busy
);

   state_t              state_reg, state_next;
   logic                dequeue_reg, dispatch_valid_reg, reenq_valid_reg, busy_reg;
   logic [TID_W-1:0]    dispatch_tid_reg, running_tid_reg, reenq_tid_reg;
   logic [INFO_W-1:0]   dispatch_info_reg, reenq_info_reg;
   logic [SLICE_W-1:0]  cnt_next;
   logic                tmr_load, tmr_en, tmr_clr;
   logic                run_exit, reenq_set;

   assign tmr_load = (state_reg == OFFER) && dispatch_ready;
   assign tmr_en   = (state_reg == RUN);
   assign tmr_clr  = (state_reg == RETIRE);

   slice_timer #(.W(SLICE_W)) u_slice_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (slice_budget(dispatch_info_reg[SLICE_W-1:0])),
      .en       (tmr_en),
      .clr      (tmr_clr),
      .cnt      (slice_cnt),
      .cnt_next (cnt_next),
      .expired  (slice_expired)
   );

   // Exit priority only matters for whether the task returns to the tail: any event ends RUN.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (!head_empty && head_schden) state_next = FETCH;
         FETCH:   state_next = OFFER;
         OFFER:   if (dispatch_ready) state_next = RUN;
         RUN:     if (task_done || preempt || yield || cnt_next == '0) state_next = RETIRE;
         RETIRE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign run_exit  = (state_reg == RUN) && (state_next == RETIRE);
   assign reenq_set = run_exit && !task_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg          <= IDLE;
         dequeue_reg        <= 1'b0;
         dispatch_valid_reg <= 1'b0;
         busy_reg           <= 1'b0;
         dispatch_tid_reg   <= '0;
         dispatch_info_reg  <= '0;
         running_tid_reg    <= '0;
         reenq_valid_reg    <= 1'b0;
         reenq_tid_reg      <= '0;
         reenq_info_reg     <= '0;
      end else begin
         state_reg          <= state_next;
         dequeue_reg        <= (state_next == FETCH);
         dispatch_valid_reg <= (state_next == OFFER);
         busy_reg           <= (state_next != IDLE);
         running_tid_reg    <= (state_next == RUN) ? dispatch_tid_reg : '0;
         reenq_valid_reg    <= reenq_set;
         // The head still shows the popped cell during FETCH; it shifts after this edge.
         if (state_reg == FETCH) begin
            dispatch_tid_reg  <= head_tid;
            dispatch_info_reg <= head_info;
         end
         if (reenq_set) begin
            reenq_tid_reg  <= dispatch_tid_reg;
            reenq_info_reg <= {dispatch_info_reg[INFO_W-1:SLICE_W], cnt_next};
         end
      end
   end

   assign dequeue        = dequeue_reg;
   assign dispatch_valid = dispatch_valid_reg;
   assign dispatch_tid   = dispatch_tid_reg;
   assign dispatch_info  = dispatch_info_reg;
   assign running_tid    = running_tid_reg;
   assign reenq_valid    = reenq_valid_reg;
   assign reenq_tid      = reenq_tid_reg;
   assign reenq_info     = reenq_info_reg;
   assign busy           = busy_reg;

endmodule

// File: tb/tb_sr_task_queue_head_dispatch.sv
// Randomized scoreboard bench for the queue-head dispatcher: a driver feeds tasks with
// an exit plan and pushes expected outcomes; an independent monitor checks the DUT.
module tb_sr_task_queue_head_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  head_tid;
   logic [31:0] head_info;
   logic        head_empty, head_schden;
   logic        dequeue, dispatch_valid, dispatch_ready;
   logic [3:0]  dispatch_tid;
   logic [31:0] dispatch_info;
   logic        preempt, yield, task_done;
   logic [3:0]  running_tid;
   logic [15:0] slice_cnt;
   logic        slice_expired, reenq_valid;
   logic [3:0]  reenq_tid;
   logic [31:0] reenq_info;
   logic        busy;

   always #5 clk = ~clk;

   sr_task_queue_head_dispatch dut (
      .clk(clk), .rst(rst),
      .head_tid(head_tid), .head_info(head_info), .head_empty(head_empty), .head_schden(head_schden),
      .dequeue(dequeue), .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_tid(dispatch_tid), .dispatch_info(dispatch_info),
      .preempt(preempt), .yield(yield), .task_done(task_done),
      .running_tid(running_tid), .slice_cnt(slice_cnt), .slice_expired(slice_expired),
      .reenq_valid(reenq_valid), .reenq_tid(reenq_tid), .reenq_info(reenq_info), .busy(busy)
   );

   // kind: 0 expire, 1 task_done, 2 preempt, 3 yield, 4 task_done+preempt; event in RUN cycle k
   typedef struct {
      logic [3:0]  tid;
      logic [31:0] info;
      int          kind;
      int          k;
      int          delay;
   } task_t;

   typedef struct {
      logic [3:0]  tid;
      logic [31:0] info;
      int          budget;
      int          run_len;
      logic        reenq;
      logic [31:0] reenq_info;
      logic        expired;
   } exp_t;

   exp_t  sb[$];
   int    n_vec  = 0;
   int    n_fail = 0;
   logic  mon_en = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctrl"}, {59'd0, dequeue, dispatch_valid, slice_expired, reenq_valid, busy}, 64'd0);
      check({tag, "_tids"}, {52'd0, dispatch_tid, running_tid, reenq_tid}, 64'd0);
      check({tag, "_dinfo"}, {32'd0, dispatch_info}, 64'd0);
      check({tag, "_rinfo"}, {32'd0, reenq_info}, 64'd0);
      check({tag, "_cnt"}, {48'd0, slice_cnt}, 64'd0);
   endtask

   function automatic task_t mk(input int tid, input logic [31:0] info, input int kind,
                                input int k, input int delay);
      task_t t;
      int    n;
      n = (info[15:0] == 16'd0) ? 100 : int'(info[15:0]);
      t.tid = tid[3:0]; t.info = info; t.delay = delay;
      t.kind = (n < 2) ? 0 : kind;
      t.k = (k < 1) ? 1 : ((k > n - 1) ? n - 1 : k);
      return t;
   endfunction

   // Reference outcome derived directly from the slice rules.
   function automatic exp_t model(input task_t t);
      exp_t e;
      int   n;
      n = (t.info[15:0] == 16'd0) ? 100 : int'(t.info[15:0]);
      e.tid = t.tid; e.info = t.info; e.budget = n;
      if (t.kind == 0) begin
         e.run_len = n; e.reenq = 1'b1; e.expired = 1'b1;
         e.reenq_info = {t.info[31:16], 16'd0};
      end else begin
         e.run_len = t.k; e.expired = 1'b0;
         e.reenq = !(t.kind == 1 || t.kind == 4);
         e.reenq_info = {t.info[31:16], 16'(n - t.k)};
      end
      return e;
   endfunction

   task automatic drive_task(input task_t t);
      int guard;
      head_tid = t.tid; head_info = t.info; head_empty = 1'b0; head_schden = 1'b1;
      guard = 0;
      do begin @(posedge clk); #1; guard++; end while (!dequeue && guard < 50);
      check("dequeue_wait", {63'd0, dequeue}, 64'd1);
      if (!dequeue) return;
      sb.push_back(model(t));
      @(posedge clk); #1;
      // The head moves on after the pop; these values must not disturb the offer.
      head_tid = 4'($urandom); head_info = $urandom; head_empty = 1'($urandom_range(0, 1));
      for (int c = 0; c <= t.delay; c++) begin
         dispatch_ready = (c == t.delay);
         preempt   = 1'($urandom_range(0, 1));
         yield     = 1'($urandom_range(0, 1));
         task_done = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      dispatch_ready = 1'b0; preempt = 1'b0; yield = 1'b0; task_done = 1'b0;
      if (t.kind != 0) begin
         repeat (t.k - 1) @(posedge clk);
         #1;
         task_done = (t.kind == 1 || t.kind == 4);
         preempt   = (t.kind == 2 || t.kind == 4);
         yield     = (t.kind == 3);
         @(posedge clk); #1;
         preempt = 1'b0; yield = 1'b0; task_done = 1'b0;
      end
      guard = 0;
      while (busy && guard < 400) begin @(posedge clk); #1; guard++; end
      check("idle_wait", {63'd0, busy}, 64'd0);
   endtask

   // Monitor: checks offers, slice run length and the retire/re-enqueue cycle.
   initial begin : monitor
      exp_t e;
      int   run_len, guard;
      logic saw_pulse;
      forever begin
         @(negedge clk);
         if (mon_en && dispatch_valid) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
               e = sb[0];
               check("offer_tid", {60'd0, dispatch_tid}, {60'd0, e.tid});
               check("offer_info", {32'd0, dispatch_info}, {32'd0, e.info});
               if (dispatch_ready) begin
                  e = sb.pop_front();
                  @(negedge clk);
                  check("run_start_cnt", {48'd0, slice_cnt}, 64'(e.budget));
                  check("run_tid", {60'd0, running_tid}, {60'd0, e.tid});
                  check("run_valid_low", {63'd0, dispatch_valid}, 64'd0);
                  run_len = 0; guard = 0; saw_pulse = 1'b0;
                  while (running_tid != 4'd0 && guard < 300) begin
                     if (slice_expired) saw_pulse = 1'b1;
                     run_len++; guard++;
                     @(negedge clk);
                  end
                  $display("task tid=%0d info=%08h run=%0d reenq=%0b reenq_info=%08h expired=%0b",
                           e.tid, e.info, run_len, reenq_valid, reenq_info, slice_expired);
                  check("run_len", 64'(run_len), 64'(e.run_len));
                  check("early_expiry", {63'd0, saw_pulse}, 64'd0);
                  check("retire_busy", {63'd0, busy}, 64'd1);
                  check("retire_expired", {63'd0, slice_expired}, {63'd0, e.expired});
                  check("reenq_valid", {63'd0, reenq_valid}, {63'd0, e.reenq});
                  if (e.reenq) begin
                     check("reenq_tid", {60'd0, reenq_tid}, {60'd0, e.tid});
                     check("reenq_info", {32'd0, reenq_info}, {32'd0, e.reenq_info});
                  end
               end
            end
         end
      end
   end

   // One-cycle pop strobe, then the offer on the following cycle.
   initial begin : pop_checker
      forever begin
         @(negedge clk);
         if (mon_en && dequeue) begin
            @(negedge clk);
            check("dequeue_pulse", {63'd0, dequeue}, 64'd0);
            check("offer_latency", {63'd0, dispatch_valid}, 64'd1);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int guard;
      rst = 1'b1;
      head_tid = 4'd0; head_info = 32'd0; head_empty = 1'b1; head_schden = 1'b0;
      dispatch_ready = 1'b0; preempt = 1'b0; yield = 1'b0; task_done = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      #2 rst = 1'b0;

      // Empty or unschedulable head: nothing may move.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         head_tid = 4'($urandom); head_info = $urandom;
         head_empty = (i % 2 == 0); head_schden = (i % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         check("empty_idle", {61'd0, dequeue, busy, dispatch_valid}, 64'd0);
      end

      drive_task(mk(5, 32'h0000_0003, 0, 1, 0));
      drive_task(mk(7, 32'hABCD_0004, 0, 1, 7));
      drive_task(mk(9, 32'h1234_000A, 2, 4, 1));
      drive_task(mk(3, 32'h5555_0007, 4, 3, 0));
      drive_task(mk(11, 32'h7700_0000, 0, 1, 2));
      drive_task(mk(12, 32'h0000_0001, 3, 1, 0));
      drive_task(mk(13, 32'hFFFF_0014, 3, 19, 0));

      for (int i = 0; i < 25; i++) begin
         logic [31:0] info;
         info = $urandom;
         info[15:0] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
         drive_task(mk($urandom_range(1, 15), info, $urandom_range(0, 4),
                       $urandom_range(1, 20), $urandom_range(0, 4)));
      end

      // Asynchronous reset in the middle of a slice.
      mon_en = 1'b0;
      head_tid = 4'd9; head_info = 32'h0000_0032; head_empty = 1'b0; head_schden = 1'b1;
      dispatch_ready = 1'b1;
      guard = 0;
      do begin @(posedge clk); #1; guard++; end while (running_tid == 4'd0 && guard < 50);
      check("mid_run_reached", {60'd0, running_tid}, 64'd9);
      head_empty = 1'b1; dispatch_ready = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      repeat (3) begin
         @(negedge clk);
         check("rst_no_reenq", {62'd0, reenq_valid, busy}, 64'd0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      mon_en = 1'b1;
      drive_task(mk(6, 32'h0BAD_0005, 2, 2, 1));

      repeat (3) @(negedge clk);
      check("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
